load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a request port and a word-wide data memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned halves/words fault instead of being force-aligned.
module load_store_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  output logic        respFault,
  output logic [31:0] respData,
  output logic [31:0] memAddr,
  input  logic [31:0] memReadData,
  output logic [31:0] memWriteData,
  output logic        memWriteEnable
);

  // state     | meaning
  // IDLE      | ready for a request
  // LOAD      | memory word addressed, read data captured at end of cycle
  // STORE     | full-word write
  // RMW_READ  | sub-word store: capture current word
  // RMW_WRITE | sub-word store: write merged word
  // RESP      | one-cycle response strobe
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [31:0] addr_eff, merged;
  logic        misalign, fault_acc;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [31:0] sh_b, sh_h;
    sh_b = w >> {a, 3'b000};
    sh_h = w >> {a[1], 4'b0000};
    case (sz)
      2'b00:   extract = {{24{sg & sh_b[7]}}, sh_b[7:0]};
      2'b01:   extract = {{16{sg & sh_h[15]}}, sh_h[15:0]};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    addr_eff = reqAddr;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (reqSize == 2'b01 && reqAddr[0]) || (reqSize == 2'b10 && reqAddr[1:0] != 2'b00);
`else
    misalign = 1'b0;
    if (reqSize == 2'b01) addr_eff[0] = 1'b0;
    if (reqSize == 2'b10) addr_eff[1:0] = 2'b00;
`endif
    fault_acc = (reqSize == 2'b11) || (reqAddr >= ADDR_LIMIT) || misalign;
  end

  always_comb begin
    logic [31:0] mask, data;
    if (size_q == 2'b00) begin
      mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      data = {4{wdata_q[7:0]}};
    end else begin
      mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      data = {2{wdata_q[15:0]}};
    end
    merged = (word_q & ~mask) | (data & mask);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
      respData  <= '0;
      respFault <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (reqValid) begin
          size_q   <= reqSize;
          signed_q <= reqSigned;
          addr_q   <= addr_eff;
          wdata_q  <= reqWdata;
          if (fault_acc) begin
            respData  <= '0;
            respFault <= 1'b1;
          end
        end
        LOAD: begin
          respData  <= extract(memReadData, addr_q[1:0], size_q, signed_q);
          respFault <= 1'b0;
        end
        RMW_READ: word_q <= memReadData;
        STORE, RMW_WRITE: begin
          respData  <= '0;
          respFault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    reqReady       = 1'b0;
    respValid      = 1'b0;
    memAddr        = '0;
    memWriteData   = '0;
    memWriteEnable = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (fault_acc)             state_nxt = RESP;
          else if (!reqWrite)        state_nxt = LOAD;
          else if (reqSize == 2'b10) state_nxt = STORE;
          else                       state_nxt = RMW_READ;
        end
      end
      LOAD: begin
        memAddr   = {2'b00, addr_q[31:2]};
        state_nxt = RESP;
      end
      STORE: begin
        memAddr        = {2'b00, addr_q[31:2]};
        memWriteData   = wdata_q;
        memWriteEnable = resetN;
        state_nxt      = RESP;
      end
      RMW_READ: begin
        memAddr   = {2'b00, addr_q[31:2]};
        state_nxt = RMW_WRITE;
      end
      RMW_WRITE: begin
        memAddr        = {2'b00, addr_q[31:2]};
        memWriteData   = merged;
        memWriteEnable = resetN;
        state_nxt      = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares whenever respValid is seen.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    time         t_acc;
  } exp_t;

  logic        clk, resetN;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respFault;
  logic [31:0] respData, memAddr, memReadData, memWriteData;
  logic        memWriteEnable;

  logic [31:0] mem [0:1023] = '{default: 32'h0};
  int          wr_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  load_store_unit dut (
    .clk(clk), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respFault(respFault), .respData(respData),
    .memAddr(memAddr), .memReadData(memReadData),
    .memWriteData(memWriteData), .memWriteEnable(memWriteEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memReadData = mem[memAddr[9:0]];

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[memAddr[9:0]] <= memWriteData;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (respValid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got respValid=1, expected none at t=%0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", respData, e.data);
        check("resp_fault", {31'b0, respFault}, {31'b0, e.fault});
        check("resp_latency", 32'(($time - e.t_acc + 5) / 10), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_fault,
                       input int exp_lat, input int exp_wr);
    exp_t e;
    int   wr0;
    @(negedge clk);
    check("req_ready", {31'b0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqSigned = sg;
    reqAddr = addr; reqWdata = wd;
    wr0 = wr_cnt;
    @(posedge clk);
    e.data = exp_data; e.fault = exp_fault; e.lat = exp_lat; e.t_acc = $time;
    sb.push_back(e);
    #1 reqValid = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no response, expected one for addr %h", addr);
      sb.delete();
    end
    check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    int wr0;
    resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqSigned = 1'b0; reqAddr = '0; reqWdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, reqReady}, 32'd1);
    check("rst_valid", {31'b0, respValid}, 32'd0);
    check("rst_fault", {31'b0, respFault}, 32'd0);
    check("rst_data", respData, 32'd0);
    check("rst_we", {31'b0, memWriteEnable}, 32'd0);
    check("rst_wdata", memWriteData, 32'd0);
    check("rst_maddr", memAddr, 32'd0);
    resetN = 1'b1;

    // word store then load at byte address 8
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'd97, 32'd0, 1'b0, 2, 1);
    check("mem2_97", mem[2], 32'd97);
    issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'd97, 1'b0, 2, 0);
    repeat (2) @(negedge clk);
    check("hold_data", respData, 32'd97);
    check("idle_valid", {31'b0, respValid}, 32'd0);
    check("idle_maddr", memAddr, 32'd0);

    // byte read-modify-write and signed/unsigned byte loads
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h1122_3344, 32'd0, 1'b0, 2, 1);
    issue(1'b1, 2'b00, 1'b1, 32'd9, 32'h0000_00F0, 32'd0, 1'b0, 3, 1);
    check("mem2_merge", mem[2], 32'h1122_F044);
    issue(1'b0, 2'b00, 1'b1, 32'd9, 32'd0, 32'hFFFF_FFF0, 1'b0, 2, 0);
    issue(1'b0, 2'b00, 1'b0, 32'd9, 32'd0, 32'h0000_00F0, 1'b0, 2, 0);
    issue(1'b0, 2'b00, 1'b0, 32'd11, 32'd0, 32'h0000_0011, 1'b0, 2, 0);

    // half loads from upper lane
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h8000_1234, 32'd0, 1'b0, 2, 1);
    issue(1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 32'hFFFF_8000, 1'b0, 2, 0);
    issue(1'b0, 2'b01, 1'b0, 32'd10, 32'd0, 32'h0000_8000, 1'b0, 2, 0);
    issue(1'b0, 2'b01, 1'b1, 32'd8, 32'd0, 32'h0000_1234, 1'b0, 2, 0);

    // half store into upper lane of word 0
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'h0102_0304, 32'd0, 1'b0, 2, 1);
    issue(1'b1, 2'b01, 1'b0, 32'd2, 32'h5555_BEEF, 32'd0, 1'b0, 3, 1);
    check("mem0_half", mem[0], 32'hBEEF_0304);

    // faults: out of range, reserved size
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1, 0);
    issue(1'b1, 2'b11, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1, 0);
    check("mem0_nofault_wr", mem[0], 32'hBEEF_0304);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0BAD_F00D, 32'd0, 1'b0, 2, 1);
    check("mem_last", mem[1023], 32'h0BAD_F00D);

    // misaligned word store
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 2'b10, 1'b0, 32'd6, 32'h55AA_55AA, 32'd0, 1'b1, 1, 0);
    check("mem1_misalign", mem[1], 32'd0);
`else
    issue(1'b1, 2'b10, 1'b0, 32'd6, 32'h55AA_55AA, 32'd0, 1'b0, 2, 1);
    check("mem1_misalign", mem[1], 32'h55AA_55AA);
`endif

    // reset while a byte store sits in RMW_READ
    issue(1'b1, 2'b10, 1'b0, 32'd16, 32'hAAAA_AAAA, 32'd0, 1'b0, 2, 1);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'd16; reqWdata = 32'h0000_0055;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, reqReady}, 32'd1);
    check("abort_valid", {31'b0, respValid}, 32'd0);
    check("abort_data", respData, 32'd0);
    resetN = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - wr0), 32'd0);
    check("abort_mem", mem[4], 32'hAAAA_AAAA);
    issue(1'b0, 2'b10, 1'b0, 32'd16, 32'd0, 32'hAAAA_AAAA, 1'b0, 2, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
